// File: rtl/rl_ram_pkg.sv
// Shared types and constants for the 1R1W RAM with collision forwarding/replay.
package rl_ram_pkg;

   // Storage macro selectors accepted by the TECHNOLOGY parameter
   localparam string TECH_GENERIC   = "GENERIC";
   localparam string TECH_N3X       = "N3X";
   localparam string TECH_N3X_LC    = "n3x";
   localparam string TECH_N3XS      = "N3XS";
   localparam string TECH_N3XS_LC   = "n3xs";
   localparam string TECH_LATTICE   = "LATTICE_DPRAM";

   // Number of byte lanes for a data width; the top lane may be partial
   function automatic int be_bits(input int dbits);
      return (dbits + 7) / 8;
   endfunction

   // Read-side control state
   typedef enum logic {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } rd_state_t;

endpackage

// File: rtl/rl_ram_1r1w_tech.sv
// Technology wrapper around the 1R1W storage. Exposes raw read data one
// cycle after a read enable; the read register holds when re_i is low so a
// suppressed read never disturbs the last value.
module rl_ram_1r1w_tech
   import rl_ram_pkg::*;
#(
   parameter int    ABITS      = 10,
   parameter int    DBITS      = 32,
   parameter string TECHNOLOGY = TECH_GENERIC,
   localparam int   BBITS      = be_bits(DBITS),
   localparam int   DEPTH      = 1 << ABITS
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [ABITS-1:0] waddr_i,
   input  logic [DBITS-1:0] din_i,
   input  logic [BBITS-1:0] be_i,
   input  logic             re_i,
   input  logic [ABITS-1:0] raddr_i,
   output logic [DBITS-1:0] rdata_o
);

   logic [DBITS-1:0] mem_q [DEPTH];
   logic [DBITS-1:0] rdata_q;
   logic [DBITS-1:0] wmask_s;

   // Reject unknown storage selectors at elaboration
   if (TECHNOLOGY != TECH_GENERIC && TECHNOLOGY != TECH_N3X    &&
       TECHNOLOGY != TECH_N3X_LC  && TECHNOLOGY != TECH_N3XS   &&
       TECHNOLOGY != TECH_N3XS_LC && TECHNOLOGY != TECH_LATTICE) begin : g_bad_tech
      $error("rl_ram_1r1w_tech: unsupported TECHNOLOGY");
   end

   // Expand byte enables into a per-bit write mask (top lane may be partial)
   always_comb begin
      wmask_s = {DBITS{1'b0}};
      for (int i = 0; i < DBITS; i++) begin
         wmask_s[i] = be_i[i / 8];
      end
   end

   // Storage write and registered read; same-address edges return pre-write data
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_s) | (din_i & wmask_s);
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rl_ram_1r1w_fwd.sv
// 1R1W RAM front end: full-word write/read collisions are forwarded from a
// capture register, partial-lane collisions are replayed from storage one
// cycle later, and reads return with a fixed latency of 1 or 2 cycles.
module rl_ram_1r1w_fwd
   import rl_ram_pkg::*;
#(
   parameter int    ABITS      = 10,
   parameter int    DBITS      = 32,
   parameter string TECHNOLOGY = TECH_GENERIC,
   parameter string INIT_FILE  = "",
   parameter int    RD_LATENCY = 1,
   localparam int   BBITS      = be_bits(DBITS)
) (
   input  logic             rst_ni,
   input  logic             clk_i,
   input  logic [ABITS-1:0] waddr_i,
   input  logic [DBITS-1:0] din_i,
   input  logic             we_i,
   input  logic [BBITS-1:0] be_i,
   input  logic [ABITS-1:0] raddr_i,
   input  logic             re_i,
   output logic             rready_o,
   output logic [DBITS-1:0] dout_o,
   output logic             rvalid_o
);

   rd_state_t        state_q, state_d;
   logic [ABITS-1:0] replay_addr_q, replay_addr_d;
   logic [DBITS-1:0] fwd_q, fwd_d;
   logic             v1_q, v1_d;
   logic             src_fwd_q, src_fwd_d;

   logic [ABITS-1:0] cmp_addr_s;
   logic             req_s;
   logic             hit_s;
   logic             full_s;
   logic             mem_re_s;
   logic             mem_we_s;
   logic [DBITS-1:0] rdata_s;
   logic [DBITS-1:0] s1_data_s;

   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("rl_ram_1r1w_fwd: RD_LATENCY must be 1 or 2");
   end

   // Writes go straight to storage; they are only blocked while in reset
   assign mem_we_s = we_i & rst_ni;

   rl_ram_1r1w_tech #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .TECHNOLOGY (TECHNOLOGY)
   ) u_tech (
      .clk_i   (clk_i),
      .we_i    (mem_we_s),
      .waddr_i (waddr_i),
      .din_i   (din_i),
      .be_i    (be_i),
      .re_i    (mem_re_s),
      .raddr_i (cmp_addr_s),
      .rdata_o (rdata_s)
   );

   // Collision detect and next-state for the read path (accept / forward / replay)
   always_comb begin
      state_d       = state_q;
      replay_addr_d = replay_addr_q;
      fwd_d         = fwd_q;
      v1_d          = 1'b0;
      src_fwd_d     = src_fwd_q;
      mem_re_s      = 1'b0;

      if (state_q == REPLAY) begin
         cmp_addr_s = replay_addr_q;
         req_s      = 1'b1;
      end else begin
         cmp_addr_s = raddr_i;
         req_s      = re_i;
      end

      hit_s  = we_i && (waddr_i == cmp_addr_s) && (be_i != {BBITS{1'b0}});
      full_s = &be_i;

      if (req_s) begin
         if (!hit_s) begin
            mem_re_s  = 1'b1;
            v1_d      = 1'b1;
            src_fwd_d = 1'b0;
            state_d   = IDLE;
         end else if (full_s) begin
            fwd_d     = din_i;
            v1_d      = 1'b1;
            src_fwd_d = 1'b1;
            state_d   = IDLE;
         end else begin
            replay_addr_d = cmp_addr_s;
            state_d       = REPLAY;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Read-control registers: FSM, replay address, forward word, stage-1 valid/source
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         replay_addr_q <= {ABITS{1'b0}};
         fwd_q         <= {DBITS{1'b0}};
         v1_q          <= 1'b0;
         src_fwd_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         replay_addr_q <= replay_addr_d;
         fwd_q         <= fwd_d;
         v1_q          <= v1_d;
         src_fwd_q     <= src_fwd_d;
      end
   end

   assign rready_o  = (state_q == IDLE);
   assign s1_data_s = src_fwd_q ? fwd_q : rdata_s;

   if (RD_LATENCY == 2) begin : g_lat2
      logic             v2_q;
      logic [DBITS-1:0] dout_q;

      // Output stage; the data register only loads on a delivered word so it holds otherwise
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            v2_q   <= 1'b0;
            dout_q <= {DBITS{1'b0}};
         end else begin
            v2_q <= v1_q;
            if (v1_q) begin
               dout_q <= s1_data_s;
            end
         end
      end

      assign rvalid_o = v2_q;
      assign dout_o   = dout_q;
   end else begin : g_lat1
      logic [DBITS-1:0] hold_q;

      // Remember the last delivered word so dout_o is stable between pulses
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            hold_q <= {DBITS{1'b0}};
         end else if (v1_q) begin
            hold_q <= s1_data_s;
         end
      end

      assign rvalid_o = v1_q;
      assign dout_o   = v1_q ? s1_data_s : hold_q;
   end

endmodule
